l1_tag_way_array: RTL and testbench

//  N-way set-associative tag/valid/dirty store for the L1 data cache. It is the

---
 rtl/l1_tag_way_array.sv | 247 ++++++++++++++++++++++++
 tb/tb_l1_tag_way_array.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/l1_tag_way_array.sv
// N-way set-associative tag/valid/dirty store for the L1 data cache.
// Handles lookup, fill, invalidate and set-dirty, chooses replacement victims and clears itself after reset.
module l1_tag_way_array #(
  parameter int TAG_WIDTH = 9,
  parameter int IDX_WIDTH = 6,
  parameter int WAYS      = 2,
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 init_done_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [IDX_WIDTH-1:0] req_idx_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic                 rsp_valid_o,
  output logic                 rsp_hit_o,
  output logic [WAY_BITS-1:0]  rsp_way_o,
  output logic                 rsp_dirty_o,
  output logic                 rsp_victim_valid_o,
  output logic                 rsp_victim_dirty_o,
  output logic [TAG_WIDTH-1:0] rsp_victim_tag_o
);

  localparam int DEPTH   = 1 << IDX_WIDTH;
  localparam int ENTRY_W = TAG_WIDTH + 2;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_INV    = 2'b10;
  localparam logic [1:0] OP_DIRTY  = 2'b11;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t state, state_next;

  logic [IDX_WIDTH-1:0] sweep_idx;
  logic                 accept;

  logic                 pend;
  logic [1:0]           pend_op;
  logic [IDX_WIDTH-1:0] pend_idx;
  logic [TAG_WIDTH-1:0] pend_tag;

  logic [ENTRY_W-1:0]   rd_q [WAYS];
  logic [WAY_BITS-1:0]  rr [DEPTH];

  logic [WAYS-1:0]      hit_vec;
  logic [WAYS-1:0]      inv_vec;
  logic                 hit;
  logic                 has_inv;
  logic [WAY_BITS-1:0]  hit_way;
  logic [WAY_BITS-1:0]  inv_way;
  logic [WAY_BITS-1:0]  victim_way;
  logic [ENTRY_W-1:0]   hit_entry;
  logic [ENTRY_W-1:0]   victim_entry;
  logic                 fill_miss;

  logic [WAYS-1:0]      we;
  logic [IDX_WIDTH-1:0] waddr;
  logic [ENTRY_W-1:0]   wdata;
  logic                 rr_we;
  logic [IDX_WIDTH-1:0] rr_waddr;
  logic [WAY_BITS-1:0]  rr_wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // The bubble after a state-changing op keeps the next read from seeing the pre-write entry.
  always_comb begin
    state_next  = state;
    init_done_o = 1'b0;
    req_ready_o = 1'b0;
    case (state)
      S_INIT: begin
        if (sweep_idx == IDX_WIDTH'(DEPTH - 1)) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        init_done_o = 1'b1;
        req_ready_o = !(pend && (pend_op != OP_LOOKUP));
      end
      default: state_next = S_INIT;
    endcase
  end

  assign accept = req_valid_i && req_ready_o && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sweep_idx <= '0;
    end else if (state == S_INIT) begin
      sweep_idx <= sweep_idx + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend     <= 1'b0;
      pend_op  <= OP_LOOKUP;
      pend_idx <= '0;
      pend_tag <= '0;
    end else begin
      pend <= accept;
      if (accept) begin
        pend_op  <= req_op_i;
        pend_idx <= req_idx_i;
        pend_tag <= req_tag_i;
      end
    end
  end

  // One read-first RAM per way; entry layout is {tag, valid, dirty}.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] q;

    always_ff @(posedge clk_i) begin
      if (we[w]) begin
        mem[waddr] <= wdata;
      end
      if (accept) begin
        q <= mem[req_idx_i];
      end
    end

    assign rd_q[w] = q;
  end

  always_ff @(posedge clk_i) begin
    if (rr_we) begin
      rr[rr_waddr] <= rr_wdata;
    end
  end

  always_comb begin
    hit_vec = '0;
    inv_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = rd_q[w][1] && (rd_q[w][ENTRY_W-1:2] == pend_tag);
      inv_vec[w] = !rd_q[w][1];
    end
  end

  // Scanning from the top down leaves the lowest matching way selected.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (inv_vec[w]) begin
        has_inv = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
  end

  assign victim_way   = has_inv ? inv_way : rr[pend_idx];
  assign hit_entry    = rd_q[hit_way];
  assign victim_entry = rd_q[victim_way];
  assign fill_miss    = (pend_op == OP_FILL) && !hit;

  always_comb begin
    we       = '0;
    waddr    = pend_idx;
    wdata    = '0;
    rr_we    = 1'b0;
    rr_waddr = pend_idx;
    rr_wdata = '0;
    if (!rst_i) begin
      if (state == S_INIT) begin
        we       = '1;
        waddr    = sweep_idx;
        rr_we    = 1'b1;
        rr_waddr = sweep_idx;
      end else if (pend) begin
        case (pend_op)
          OP_FILL: begin
            wdata = {pend_tag, 2'b10};
            if (hit) begin
              we[hit_way] = 1'b1;
            end else begin
              we[victim_way] = 1'b1;
              // Round-robin only advances when it actually picked the victim.
              if ((WAYS > 1) && !has_inv) begin
                rr_we    = 1'b1;
                rr_wdata = rr[pend_idx] + WAY_BITS'(1);
              end
            end
          end
          OP_INV: begin
            if (hit) begin
              we[hit_way] = 1'b1;
              wdata       = {hit_entry[ENTRY_W-1:2], 2'b00};
            end
          end
          OP_DIRTY: begin
            if (hit) begin
              we[hit_way] = 1'b1;
              wdata       = {hit_entry[ENTRY_W-1:2], 2'b11};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Response fields only change when a response is produced and hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o        <= 1'b0;
      rsp_hit_o          <= 1'b0;
      rsp_way_o          <= '0;
      rsp_dirty_o        <= 1'b0;
      rsp_victim_valid_o <= 1'b0;
      rsp_victim_dirty_o <= 1'b0;
      rsp_victim_tag_o   <= '0;
    end else begin
      rsp_valid_o <= pend;
      if (pend) begin
        rsp_hit_o          <= hit;
        rsp_way_o          <= hit ? hit_way : (fill_miss ? victim_way : '0);
        rsp_dirty_o        <= hit && hit_entry[0];
        rsp_victim_valid_o <= fill_miss && victim_entry[1];
        rsp_victim_dirty_o <= fill_miss && victim_entry[1] && victim_entry[0];
        rsp_victim_tag_o   <= (fill_miss && victim_entry[1]) ? victim_entry[ENTRY_W-1:2] : '0;
      end
    end
  end

endmodule

// File: tb/tb_l1_tag_way_array.sv
// Directed bench for l1_tag_way_array with the default 9-bit tag, 64-set, 2-way configuration.
module tb_l1_tag_way_array;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_INV    = 2'b10;
  localparam logic [1:0] OP_DIRTY  = 2'b11;

  logic       clk;
  logic       rst;
  logic       init_done;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [5:0] req_idx;
  logic [8:0] req_tag;
  logic       rsp_valid;
  logic       rsp_hit;
  logic [0:0] rsp_way;
  logic       rsp_dirty;
  logic       rsp_victim_valid;
  logic       rsp_victim_dirty;
  logic [8:0] rsp_victim_tag;

  int total = 0;
  int bad   = 0;

  l1_tag_way_array #(
    .TAG_WIDTH(9),
    .IDX_WIDTH(6),
    .WAYS(2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .init_done_o       (init_done),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_op_i          (req_op),
    .req_idx_i         (req_idx),
    .req_tag_i         (req_tag),
    .rsp_valid_o       (rsp_valid),
    .rsp_hit_o         (rsp_hit),
    .rsp_way_o         (rsp_way),
    .rsp_dirty_o       (rsp_dirty),
    .rsp_victim_valid_o(rsp_victim_valid),
    .rsp_victim_dirty_o(rsp_victim_dirty),
    .rsp_victim_tag_o  (rsp_victim_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rsp(input string name, input logic [31:0] e_hit, input logic [31:0] e_way,
                           input logic [31:0] e_dirty, input logic [31:0] e_vv,
                           input logic [31:0] e_vd, input logic [31:0] e_vt, input bit chk_vt);
    check({name, ".valid"}, 32'(rsp_valid), 32'd1);
    check({name, ".hit"}, 32'(rsp_hit), e_hit);
    check({name, ".way"}, 32'(rsp_way), e_way);
    check({name, ".dirty"}, 32'(rsp_dirty), e_dirty);
    check({name, ".vvalid"}, 32'(rsp_victim_valid), e_vv);
    check({name, ".vdirty"}, 32'(rsp_victim_dirty), e_vd);
    if (chk_vt) check({name, ".vtag"}, 32'(rsp_victim_tag), e_vt);
  endtask

  // Starts and ends on a falling edge; returns with the response on the outputs.
  task automatic do_op(input string name, input logic [1:0] op, input logic [5:0] idx,
                       input logic [8:0] tag, input logic [31:0] e_hit, input logic [31:0] e_way,
                       input logic [31:0] e_dirty, input logic [31:0] e_vv,
                       input logic [31:0] e_vd, input logic [31:0] e_vt, input bit chk_vt);
    req_valid = 1'b1;
    req_op    = op;
    req_idx   = idx;
    req_tag   = tag;
    check({name, ".ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    tick();
    check_rsp(name, e_hit, e_way, e_dirty, e_vv, e_vd, e_vt, chk_vt);
  endtask

  task automatic wait_sweep(input string name);
    int cnt = 0;
    check({name, ".ready_low"}, 32'(req_ready), 32'd0);
    while (!req_ready && cnt < 200) begin
      tick();
      cnt++;
    end
    check({name, ".cycles"}, 32'(cnt), 32'd64);
    check({name, ".init_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_LOOKUP;
    req_idx   = '0;
    req_tag   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.init_done", 32'(init_done), 32'd0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_hit", 32'(rsp_hit), 32'd0);
    check("reset.vtag", 32'(rsp_victim_tag), 32'd0);
    rst = 1'b0;
    wait_sweep("sweep1");

    do_op("lk_empty", OP_LOOKUP, 6'd5, 9'h1A3, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("lk_empty.one_cycle", 32'(rsp_valid), 32'd0);

    do_op("fill_a", OP_FILL, 6'd5, 9'h1A3, 0, 0, 0, 0, 0, 0, 1);
    do_op("fill_b", OP_FILL, 6'd5, 9'h0F0, 0, 1, 0, 0, 0, 0, 1);
    do_op("lk_b", OP_LOOKUP, 6'd5, 9'h0F0, 1, 1, 0, 0, 0, 0, 1);

    req_valid = 1'b1;
    req_op    = OP_LOOKUP;
    req_idx   = 6'd5;
    req_tag   = 9'h1A3;
    tick();
    req_tag = 9'h0F0;
    check("b2b.ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check_rsp("b2b.first", 1, 0, 0, 0, 0, 0, 1);
    tick();
    check_rsp("b2b.second", 1, 1, 0, 0, 0, 0, 1);
    tick();
    check("b2b.idle", 32'(rsp_valid), 32'd0);

    do_op("dirty_a", OP_DIRTY, 6'd5, 9'h1A3, 1, 0, 0, 0, 0, 0, 1);
    do_op("evict_a", OP_FILL, 6'd5, 9'h055, 0, 0, 0, 1, 1, 9'h1A3, 1);
    do_op("evict_b", OP_FILL, 6'd5, 9'h077, 0, 1, 0, 1, 0, 9'h0F0, 1);

    do_op("inv_hit", OP_INV, 6'd5, 9'h055, 1, 0, 0, 0, 0, 0, 1);
    do_op("lk_inv", OP_LOOKUP, 6'd5, 9'h055, 0, 0, 0, 0, 0, 0, 1);
    do_op("inv_miss", OP_INV, 6'd5, 9'h0AA, 0, 0, 0, 0, 0, 0, 1);
    do_op("lk_keep", OP_LOOKUP, 6'd5, 9'h077, 1, 1, 0, 0, 0, 0, 1);
    do_op("fill_hole", OP_FILL, 6'd5, 9'h123, 0, 0, 0, 0, 0, 0, 0);
    do_op("fill_rr", OP_FILL, 6'd5, 9'h1FF, 0, 0, 0, 1, 0, 9'h123, 1);

    req_valid = 1'b1;
    req_op    = OP_FILL;
    req_idx   = 6'd9;
    req_tag   = 9'h011;
    tick();
    check("bubble.ready", 32'(req_ready), 32'd0);
    req_op = OP_LOOKUP;
    tick();
    req_valid = 1'b0;
    check_rsp("bubble.fill", 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("bubble.ignored", 32'(rsp_valid), 32'd0);

    do_op("refill", OP_FILL, 6'd5, 9'h077, 1, 1, 0, 0, 0, 0, 1);
    do_op("dirty_c", OP_DIRTY, 6'd9, 9'h011, 1, 0, 0, 0, 0, 0, 1);
    do_op("refill_dirty", OP_FILL, 6'd9, 9'h011, 1, 0, 1, 0, 0, 0, 1);
    do_op("lk_clean", OP_LOOKUP, 6'd9, 9'h011, 1, 0, 0, 0, 0, 0, 1);
    tick();
    check("hold.valid", 32'(rsp_valid), 32'd0);
    check("hold.hit", 32'(rsp_hit), 32'd1);

    req_valid = 1'b1;
    req_op    = OP_FILL;
    req_idx   = 6'd9;
    req_tag   = 9'h022;
    tick();
    req_valid = 1'b0;
    rst       = 1'b1;
    tick();
    check("rst_rsp.valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp.hit", 32'(rsp_hit), 32'd0);
    check("rst_rsp.ready", 32'(req_ready), 32'd0);
    check("rst_rsp.init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("mid_sweep.ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_sweep.init_done", 32'(init_done), 32'd0);
    wait_sweep("sweep2");

    do_op("post_a", OP_LOOKUP, 6'd5, 9'h1FF, 0, 0, 0, 0, 0, 0, 1);
    do_op("post_b", OP_LOOKUP, 6'd5, 9'h077, 0, 0, 0, 0, 0, 0, 1);
    do_op("post_c", OP_LOOKUP, 6'd9, 9'h011, 0, 0, 0, 0, 0, 0, 1);
    do_op("post_d", OP_LOOKUP, 6'd9, 9'h022, 0, 0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
